// File: rtl/jacobi_seq_ctrl.sv
// rtl/jacobi_seq_ctrl.sv - sequencing controller that feeds, runs and drains a Jacobi solver
//
// Purpose: on start, latches the solve configuration, pulses the solver's go,
// streams N B values then N*N A values (row-major) into the solver, one load
// every other cycle at most, waits for the solver's ready, and then emits the
// N solution values as a result stream. The controller also reports done, fail
// and err, and the cycle count from go to solver ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle solve request (sampled only in IDLE)
//   cfg_n/cfg_max_iter/cfg_thresh   configuration, latched on accepted start
//   s_data/s_valid/s_ready   coefficient input stream (B values, then A values)
//   j_go/j_load_B/j_load_A   solver control pulses
//   j_B_next/j_A_next        solver load data (s_data while loading, else held)
//   j_N/j_max_iter/j_threshold      latched configuration toward the solver
//   j_drdy/j_dout/j_fail     solver results
//   r_data/r_valid/r_last    result stream, no backpressure
//   busy/done/fail/err/latency      status
module jacobi_seq_ctrl #(
   parameter int MAX_N = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         cfg_n,
   input  logic [15:0]        cfg_max_iter,
   input  logic [26:0]        cfg_thresh,
   input  logic signed [26:0] s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic               j_go,
   output logic               j_load_A,
   output logic               j_load_B,
   output logic signed [26:0] j_A_next,
   output logic signed [26:0] j_B_next,
   output logic [7:0]         j_N,
   output logic [15:0]        j_max_iter,
   output logic [26:0]        j_threshold,
   input  logic               j_drdy,
   input  logic signed [26:0] j_dout,
   input  logic               j_fail,
   output logic signed [26:0] r_data,
   output logic               r_valid,
   output logic               r_last,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic               err,
   output logic [31:0]        latency
);

   typedef enum logic [2:0] {
      S_IDLE, S_GO, S_LOAD_B, S_LOAD_A, S_WAIT, S_COLLECT, S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic               gap_q, gap_d;      // 1 = mandatory idle cycle after an accept
   logic [15:0]        cnt_q, cnt_d;      // elements loaded / results emitted
   logic [7:0]         n_q;
   logic [15:0]        max_iter_q;
   logic [26:0]        thresh_q;
   logic signed [26:0] a_hold_q, b_hold_q, r_data_q;
   logic               fail_q, err_q;
   logic [31:0]        lat_q;

   logic [15:0]        nn;
   logic [15:0]        n_last;
   logic               cfg_bad;
   logic               latch_cfg, capture, set_fail, count_lat;

   assign nn      = 16'(n_q) * 16'(n_q);
   assign n_last  = 16'(n_q) - 16'd1;
   assign cfg_bad = (cfg_n == 8'd0) || (int'(cfg_n) > MAX_N);

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      s_ready   = 1'b0;
      j_go      = 1'b0;
      j_load_A  = 1'b0;
      j_load_B  = 1'b0;
      r_valid   = 1'b0;
      r_last    = 1'b0;
      done      = 1'b0;
      latch_cfg = 1'b0;
      capture   = 1'b0;
      set_fail  = 1'b0;
      count_lat = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               latch_cfg = 1'b1;
               state_d   = cfg_bad ? S_FIN : S_GO;
            end
         end
         S_GO: begin
            j_go      = 1'b1;
            count_lat = 1'b1;
            gap_d     = 1'b0;
            cnt_d     = 16'd0;
            state_d   = S_LOAD_B;
         end
         S_LOAD_B: begin
            count_lat = 1'b1;
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  j_load_B = 1'b1;
                  gap_d    = 1'b1;
                  // The gap flag survives the move to LOAD_A, so its first cycle is idle.
                  if (cnt_q == n_last) begin
                     cnt_d   = 16'd0;
                     state_d = S_LOAD_A;
                  end else begin
                     cnt_d = cnt_q + 16'd1;
                  end
               end
            end
         end
         S_LOAD_A: begin
            count_lat = 1'b1;
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  j_load_A = 1'b1;
                  gap_d    = 1'b1;
                  if (cnt_q == nn - 16'd1) begin
                     cnt_d   = 16'd0;
                     state_d = S_WAIT;
                  end else begin
                     cnt_d = cnt_q + 16'd1;
                  end
               end
            end
         end
         S_WAIT: begin
            // The drdy cycle itself is still counted; WAIT is left on that edge.
            count_lat = 1'b1;
            if (j_drdy) begin
               if (j_fail) begin
                  set_fail = 1'b1;
                  state_d  = S_FIN;
               end else begin
                  capture = 1'b1;
                  cnt_d   = 16'd0;
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            r_valid = 1'b1;
            if (cnt_q == n_last) begin
               r_last  = 1'b1;
               state_d = S_FIN;
            end else begin
               // Keep r_data stable after the last element by not capturing then.
               capture = 1'b1;
               cnt_d   = cnt_q + 16'd1;
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gap_q      <= 1'b0;
         cnt_q      <= 16'd0;
         n_q        <= 8'd0;
         max_iter_q <= 16'd0;
         thresh_q   <= 27'd0;
         a_hold_q   <= '0;
         b_hold_q   <= '0;
         r_data_q   <= '0;
         fail_q     <= 1'b0;
         err_q      <= 1'b0;
         lat_q      <= 32'd0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         if (latch_cfg) begin
            n_q        <= cfg_n;
            max_iter_q <= cfg_max_iter;
            thresh_q   <= cfg_thresh;
            fail_q     <= 1'b0;
            err_q      <= cfg_bad;
            lat_q      <= 32'd0;
         end
         if (j_load_B) b_hold_q <= s_data;
         if (j_load_A) a_hold_q <= s_data;
         if (capture)  r_data_q <= j_dout;
         if (set_fail) fail_q   <= 1'b1;
         if (count_lat && (lat_q != 32'hFFFF_FFFF)) lat_q <= lat_q + 32'd1;
      end
   end

   assign j_B_next    = j_load_B ? s_data : b_hold_q;
   assign j_A_next    = j_load_A ? s_data : a_hold_q;
   assign j_N         = n_q;
   assign j_max_iter  = max_iter_q;
   assign j_threshold = thresh_q;
   assign r_data      = r_data_q;
   assign busy        = (state_q != S_IDLE);
   assign fail        = fail_q;
   assign err         = err_q;
   assign latency     = lat_q;

endmodule

// File: tb/tb_jacobi_seq_ctrl.sv
// tb/tb_jacobi_seq_ctrl.sv - randomized self-checking bench for jacobi_seq_ctrl
module tb_jacobi_seq_ctrl;

   logic               clk = 1'b0;
   logic               rst, start;
   logic [7:0]         cfg_n;
   logic [15:0]        cfg_max_iter;
   logic [26:0]        cfg_thresh;
   logic signed [26:0] s_data;
   logic               s_valid, s_ready;
   logic               j_go, j_load_A, j_load_B;
   logic signed [26:0] j_A_next, j_B_next;
   logic [7:0]         j_N;
   logic [15:0]        j_max_iter;
   logic [26:0]        j_threshold;
   logic               j_drdy, j_fail;
   logic signed [26:0] j_dout;
   logic signed [26:0] r_data;
   logic               r_valid, r_last, busy, done, fail, err;
   logic [31:0]        latency;

   jacobi_seq_ctrl #(.MAX_N(100)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_n(cfg_n), .cfg_max_iter(cfg_max_iter), .cfg_thresh(cfg_thresh),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .j_go(j_go), .j_load_A(j_load_A), .j_load_B(j_load_B),
      .j_A_next(j_A_next), .j_B_next(j_B_next),
      .j_N(j_N), .j_max_iter(j_max_iter), .j_threshold(j_threshold),
      .j_drdy(j_drdy), .j_dout(j_dout), .j_fail(j_fail),
      .r_data(r_data), .r_valid(r_valid), .r_last(r_last),
      .busy(busy), .done(done), .fail(fail), .err(err), .latency(latency)
   );

   always #5 clk = ~clk;

   int                 vec_cnt = 0;
   int                 err_cnt = 0;
   logic signed [26:0] stream[$];
   logic signed [26:0] res[$];
   logic signed [26:0] last_a = '0;
   logic signed [26:0] last_b = '0;
   int                 load_c[$];
   int                 obs_ld[$];
   int                 obs_r[$];
   int                 drop_lo = -1;
   int                 drop_hi = -2;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_q(input string nm, input int got[$], input int exp[$]);
      chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
      foreach (exp[i]) if (i < got.size()) chk(nm, 64'(got[i]), 64'(exp[i]));
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start = 1'b0; cfg_n = 8'd0; cfg_max_iter = 16'd0; cfg_thresh = 27'd0;
      s_valid = 1'b0; s_data = '0; j_drdy = 1'b0; j_fail = 1'b0; j_dout = '0;
   endtask

   // Caller drives rst for the cycle before; this samples the cycle after that edge.
   task automatic post_reset_check();
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("rst_busy", busy, 0);        chk("rst_s_ready", s_ready, 0);
      chk("rst_j_go", j_go, 0);        chk("rst_load_A", j_load_A, 0);
      chk("rst_load_B", j_load_B, 0);  chk("rst_r_valid", r_valid, 0);
      chk("rst_r_last", r_last, 0);    chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);        chk("rst_err", err, 0);
      chk("rst_latency", latency, 0);  chk("rst_A_next", j_A_next, 0);
      chk("rst_B_next", j_B_next, 0);  chk("rst_r_data", r_data, 0);
      chk("rst_j_N", j_N, 0);          chk("rst_max_iter", j_max_iter, 0);
      chk("rst_thresh", j_threshold, 0);
      last_a = '0;
      last_b = '0;
   endtask

   task automatic rand_stream(input int n);
      stream.delete();
      res.delete();
      for (int i = 0; i < n + n * n; i++) stream.push_back(27'($urandom));
      for (int i = 0; i < n; i++) res.push_back(27'($urandom));
   endtask

   // Cycle c=0 carries start; GO is c=1. Loads happen on handshakes of an
   // accept cycle (any load-phase cycle not directly after a handshake).
   task automatic run_solve(input int n, input int vpct, input bit efail, input bit spur,
                            input int abort_at, input int dly);
      int          total, drdy_c, fin_c, wcnt, limit, c, sidx;
      bit          bad, prev_hs, hs, exp_rdy, rv, finished, aborted;
      logic [15:0] mi;
      logic [26:0] th;
      bad      = (n == 0) || (n > 100);
      total    = bad ? 0 : n + n * n;
      limit    = 8 * total + 100;
      mi       = 16'($urandom);
      th       = 27'($urandom);
      sidx     = 0;
      prev_hs  = 1'b0;
      drdy_c   = -1;
      fin_c    = bad ? 1 : 32'h3FFF_FFFF;
      wcnt     = dly;
      finished = 1'b0;
      aborted  = 1'b0;
      load_c.delete(); obs_ld.delete(); obs_r.delete();
      c = 0;
      while (!finished && !aborted && c < limit) begin
         @(posedge clk); #1;
         idle_inputs();
         start        = (c == 0);
         cfg_n        = 8'(n);
         cfg_max_iter = mi;
         cfg_thresh   = th;
         j_dout       = 27'($urandom);
         if (abort_at >= 0 && c >= 2 && sidx == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            post_reset_check();
            aborted = 1'b1;
         end else begin
            exp_rdy = !bad && c >= 2 && sidx < total && !prev_hs;
            if (!bad && c >= 2 && sidx < total) s_valid = ($urandom_range(99) < vpct);
            if (c >= drop_lo && c <= drop_hi) s_valid = 1'b0;
            if (sidx < total) s_data = stream[sidx];
            if (!bad && sidx == total && drdy_c < 0) begin
               if (wcnt == 0) begin
                  j_drdy = 1'b1;
                  j_fail = efail;
                  j_dout = res[0];
                  drdy_c = c;
                  fin_c  = c + (efail ? 1 : n + 1);
               end else begin
                  wcnt--;
               end
            end else if (drdy_c >= 0 && c - drdy_c < n) begin
               j_dout = res[c - drdy_c];
            end else if (spur && !bad && c >= 1 && sidx < total) begin
               j_drdy = 1'($urandom_range(1));
               j_fail = 1'b1;
            end
            @(negedge clk);
            hs = exp_rdy && s_valid;
            chk("busy", busy, c >= 1 && c <= fin_c);
            chk("done", done, c == fin_c);
            chk("j_go", j_go, !bad && c == 1);
            chk("s_ready", s_ready, exp_rdy);
            chk("j_load_B", j_load_B, hs && sidx < n);
            chk("j_load_A", j_load_A, hs && sidx >= n);
            if (hs && sidx < n)  last_b = stream[sidx];
            if (hs && sidx >= n) last_a = stream[sidx];
            chk("j_B_next", j_B_next, last_b);
            chk("j_A_next", j_A_next, last_a);
            rv = drdy_c >= 0 && !efail && c > drdy_c && c <= drdy_c + n;
            chk("r_valid", r_valid, rv);
            chk("r_last", r_last, rv && c == drdy_c + n);
            if (rv) chk("r_data", r_data, res[c - drdy_c - 1]);
            if (c >= 1) begin
               chk("j_N", j_N, 8'(n));
               chk("j_max_iter", j_max_iter, mi);
               chk("j_threshold", j_threshold, th);
            end
            if (c == 1 && !bad) begin
               chk("start_clr_lat", latency, 0);
               chk("start_clr_fail", fail, 0);
               chk("start_clr_err", err, 0);
            end
            if (c == fin_c) begin
               chk("fin_fail", fail, efail && !bad);
               chk("fin_err", err, bad);
               chk("fin_latency", latency, bad ? 0 : drdy_c);
               finished = 1'b1;
            end
            if (j_load_A || j_load_B) begin
               load_c.push_back(c);
               obs_ld.push_back(int'(j_load_B ? j_B_next : j_A_next));
            end
            if (r_valid) obs_r.push_back(int'(r_data));
            if (hs) sidx++;
            prev_hs = hs;
            c++;
         end
      end
      if (!finished && !aborted) chk("run_timeout", 1, 0);
      if (finished) begin
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         chk("post_busy", busy, 0);
         chk("post_done", done, 0);
         chk("hold_fail", fail, efail && !bad);
         chk("hold_err", err, bad);
         chk("hold_latency", latency, bad ? 0 : drdy_c);
      end
   endtask

   initial begin
      int e_lc[$];
      int e_ld[$];
      int e_r[$];
      int empty[$];
      idle_inputs();
      rst = 1'b1;
      post_reset_check();

      // N=2 directed solve, continuous s_valid.
      stream = '{27'sd5, 27'sd7, 27'sd4, 27'sd1, 27'sd1, 27'sd3};
      res    = '{27'sd11, 27'sd13};
      run_solve(2, 100, 1'b0, 1'b0, -1, 0);
      e_lc = '{2, 4, 6, 8, 10, 12};
      e_ld = '{5, 7, 4, 1, 1, 3};
      e_r  = '{11, 13};
      chk_q("dir_load_cycle", load_c, e_lc);
      chk_q("dir_load_data", obs_ld, e_ld);
      chk_q("dir_result", obs_r, e_r);
      chk("dir_latency", latency, 13);

      // s_valid dropped for three cycles in LOAD_A.
      drop_lo = 7;
      drop_hi = 9;
      run_solve(2, 100, 1'b0, 1'b0, -1, 0);
      drop_lo = -1;
      drop_hi = -2;
      e_lc = '{2, 4, 6, 10, 12, 14};
      chk_q("drop_load_cycle", load_c, e_lc);
      chk_q("drop_load_data", obs_ld, e_ld);
      chk("drop_latency", latency, 15);

      // Solver failure.
      rand_stream(3);
      run_solve(3, 80, 1'b1, 1'b0, -1, 2);
      chk_q("fail_result", obs_r, empty);

      // Out-of-range orders.
      run_solve(0, 100, 1'b0, 1'b0, -1, 0);
      chk_q("n0_loads", load_c, empty);
      run_solve(101, 100, 1'b0, 1'b0, -1, 0);
      chk_q("n101_loads", load_c, empty);

      // Reset in the middle of LOAD_A, then a clean N=1 solve.
      rand_stream(3);
      run_solve(3, 100, 1'b0, 1'b0, 5, 0);
      stream = '{27'sd9, -27'sd2};
      res    = '{27'sd21};
      run_solve(1, 100, 1'b0, 1'b0, -1, 0);
      e_lc = '{2, 4};
      e_ld = '{9, -2};
      e_r  = '{21};
      chk_q("n1_load_cycle", load_c, e_lc);
      chk_q("n1_load_data", obs_ld, e_ld);
      chk_q("n1_result", obs_r, e_r);
      chk("n1_latency", latency, 5);

      // Reset wins over a simultaneous start.
      @(posedge clk); #1;
      idle_inputs();
      rst          = 1'b1;
      start        = 1'b1;
      cfg_n        = 8'd3;
      cfg_max_iter = 16'h1234;
      cfg_thresh   = 27'h55;
      @(negedge clk);
      post_reset_check();

      // Randomized solves, including stray solver drdy pulses during loads.
      for (int k = 0; k < 20; k++) begin
         int rn;
         rn = $urandom_range(1, 6);
         rand_stream(rn);
         run_solve(rn, $urandom_range(30, 100), ($urandom_range(3) == 0),
                   1'($urandom_range(1)), -1, $urandom_range(0, 5));
      end

      // Largest accepted order.
      rand_stream(100);
      run_solve(100, 100, 1'b0, 1'b1, -1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
